// File: rtl/lisp_defs_pkg.sv
// Shared definitions for the evaluator memory subsystem: memory opcodes,
// the NIL word and memory error codes.
package lisp_defs;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_WRITE = 2'd1,
        MEM_CONS  = 2'd2,
        MEM_RSVD  = 2'd3
    } mem_op_t;

    localparam logic [15:0] LISP_NIL = 16'h0000;

    localparam logic [1:0] MEM_ERR_NONE = 2'd0;
    localparam logic [1:0] MEM_ERR_FULL = 2'd1;
    localparam logic [1:0] MEM_ERR_ADDR = 2'd2;

endpackage

// File: rtl/cell_memory_ram.sv
// cell_ram: single-port synchronous RAM of 16-bit words, one-cycle read
// latency, write-first on a write cycle.
module cell_ram #(
    parameter int    DEPTH     = 256,
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem_r [DEPTH];

    // Registered read, write-first so a write cycle returns the new word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
            rdata       <= wdata;
        end else begin
            rdata       <= mem_r[addr];
        end
    end

endmodule

// File: rtl/cell_memory.sv
// cell_memory: heap/cell store behind the evaluator memory port.
// READ (2 cycles), WRITE (1 cycle), CONS (bump-allocates car/cdr, 2 cycles).
// Optional macro CELL_MEM_BOUNDS_CHECK_EN: out-of-range READ/WRITE and WRITE
// into the program image below HEAP_BASE complete with err instead of aliasing.
module cell_memory
    import lisp_defs::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [15:0] HEAP_BASE = 16'h0010,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata,
    input  logic [15:0] wdata_cdr,
    output logic        data_ready,
    output logic [15:0] data_out,
    output logic        busy,
    output logic        err,
    output logic [15:0] free_ptr
);

    localparam int          ADDR_W = $clog2(DEPTH);
    localparam logic [16:0] LAST_W = 17'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_DONE  = 3'd2,
        ST_WR_DONE  = 3'd3,
        ST_CONS_CDR = 3'd4,
        ST_DONE_ERR = 3'd5
    } cell_mem_state_t;

    cell_mem_state_t   state_r, state_nxt_s;
    mem_op_t           op_r, op_in_s;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wdata_r, cdr_r;
    logic              data_ready_r, busy_r, err_r;
    logic [15:0]       data_out_r, free_ptr_r;
    logic              ready_nxt_s, err_nxt_s, latch_s;
    logic [15:0]       dout_nxt_s, fp_nxt_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [15:0]       ram_wdata_s, ram_rdata_s;
    logic [16:0]       fp_inc1_s, fp_inc2_s;
    logic              heap_full_s, rd_bad_s, wr_bad_s;

    assign op_in_s     = mem_op_t'(op);
    assign fp_inc1_s   = {1'b0, free_ptr_r} + 17'd1;
    assign fp_inc2_s   = {1'b0, free_ptr_r} + 17'd2;
    // Both words of the new cell must fit below DEPTH.
    assign heap_full_s = (fp_inc1_s > LAST_W);

`ifdef CELL_MEM_BOUNDS_CHECK_EN
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    assign rd_bad_s = ({1'b0, addr_in} >= DEPTH_W);
    assign wr_bad_s = rd_bad_s || (addr_in < HEAP_BASE);
`else
    // Upper address bits are dropped: addresses alias modulo DEPTH.
    logic unused_addr_s;
    assign rd_bad_s      = 1'b0;
    assign wr_bad_s      = 1'b0;
    assign unused_addr_s = ^addr_in[15:ADDR_W];
`endif

    cell_ram #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s & ~rst),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, RAM control and next values of the registered outputs.
    always_comb begin
        state_nxt_s = state_r;
        ready_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        dout_nxt_s  = data_out_r;
        fp_nxt_s    = free_ptr_r;
        latch_s     = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = addr_r;
        ram_wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    latch_s = 1'b1;
                    case (op_in_s)
                        MEM_READ: begin
                            if (rd_bad_s) begin
                                state_nxt_s = ST_DONE_ERR;
                            end else begin
                                state_nxt_s = ST_RD_WAIT;
                            end
                        end
                        MEM_WRITE: begin
                            if (wr_bad_s) begin
                                state_nxt_s = ST_DONE_ERR;
                            end else begin
                                state_nxt_s = ST_WR_DONE;
                            end
                        end
                        MEM_CONS: begin
                            if (heap_full_s) begin
                                state_nxt_s = ST_DONE_ERR;
                            end else begin
                                state_nxt_s = ST_WR_DONE;
                            end
                        end
                        default: state_nxt_s = ST_DONE_ERR;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                state_nxt_s = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                ready_nxt_s = 1'b1;
                dout_nxt_s  = ram_rdata_s;
                state_nxt_s = ST_IDLE;
            end
            ST_WR_DONE: begin
                ram_we_s = 1'b1;
                if (op_r == MEM_CONS) begin
                    // Car goes to the current free word; cdr follows next cycle.
                    ram_addr_s  = free_ptr_r[ADDR_W-1:0];
                    state_nxt_s = ST_CONS_CDR;
                end else begin
                    ready_nxt_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONS_CDR: begin
                ram_we_s    = 1'b1;
                ram_addr_s  = fp_inc1_s[ADDR_W-1:0];
                ram_wdata_s = cdr_r;
                ready_nxt_s = 1'b1;
                dout_nxt_s  = free_ptr_r;
                if (fp_inc2_s[16]) begin
                    fp_nxt_s = 16'hFFFF;
                end else begin
                    fp_nxt_s = fp_inc2_s[15:0];
                end
                state_nxt_s = ST_IDLE;
            end
            ST_DONE_ERR: begin
                ready_nxt_s = 1'b1;
                err_nxt_s   = 1'b1;
                dout_nxt_s  = LISP_NIL;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request latches, captured only on acceptance in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= MEM_READ;
            addr_r  <= '0;
            wdata_r <= 16'h0000;
            cdr_r   <= 16'h0000;
        end else if (latch_s) begin
            op_r    <= op_in_s;
            addr_r  <= addr_in[ADDR_W-1:0];
            wdata_r <= wdata;
            cdr_r   <= wdata_cdr;
        end else begin
            op_r    <= op_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            cdr_r   <= cdr_r;
        end
    end

    // Output registers; busy covers the whole transaction including data_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_ready_r <= 1'b0;
            data_out_r   <= LISP_NIL;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
            free_ptr_r   <= HEAP_BASE;
        end else begin
            data_ready_r <= ready_nxt_s;
            data_out_r   <= dout_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE) || ready_nxt_s;
            err_r        <= err_nxt_s;
            free_ptr_r   <= fp_nxt_s;
        end
    end

    assign data_ready = data_ready_r;
    assign data_out   = data_out_r;
    assign busy       = busy_r;
    assign err        = err_r;
    assign free_ptr   = free_ptr_r;

endmodule

// File: tb/tb_cell_memory.sv
// Self-checking bench for cell_memory (DEPTH=32). Expected behaviour comes
// from an array/pointer model of the heap. Honours CELL_MEM_BOUNDS_CHECK_EN.
module tb_cell_memory;
    import lisp_defs::*;

    localparam int          DEPTH     = 32;
    localparam logic [15:0] HEAP_BASE = 16'h0010;
`ifdef CELL_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] addr_in = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] wdata_cdr = 16'h0000;
    logic        data_ready, busy, err;
    logic [15:0] data_out, free_ptr;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [15:0] mem_m [DEPTH];
    bit          known_m [DEPTH];
    int          fp_m;
    logic [15:0] dout_m;
    bit          dout_known_m;

    cell_memory #(.DEPTH(DEPTH), .HEAP_BASE(HEAP_BASE), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr_in(addr_in),
        .wdata(wdata), .wdata_cdr(wdata_cdr), .data_ready(data_ready),
        .data_out(data_out), .busy(busy), .err(err), .free_ptr(free_ptr)
    );

    always #5 clk = ~clk;

    // Model one request: latency in cycles after acceptance, err, result word.
    task automatic model_apply(input logic [1:0] o, input logic [15:0] a, input logic [15:0] w,
                               input logic [15:0] c, output int lat, output logic [15:0] d,
                               output logic e, output bit dk);
        int idx;
        bit bad_rd, bad_wr;
        idx    = int'(a) % DEPTH;
        bad_rd = BOUNDS && (int'(a) >= DEPTH);
        bad_wr = bad_rd || (BOUNDS && (a < HEAP_BASE));
        e = 1'b1; lat = 1; d = LISP_NIL; dk = 1'b1;
        if (o == 2'd0 && !bad_rd) begin
            e = 1'b0; lat = 2; d = mem_m[idx]; dk = known_m[idx];
        end else if (o == 2'd1 && !bad_wr) begin
            e = 1'b0; lat = 1; d = dout_m; dk = dout_known_m;
            mem_m[idx] = w; known_m[idx] = 1'b1;
        end else if (o == 2'd2 && (fp_m + 1 <= DEPTH - 1)) begin
            e = 1'b0; lat = 2; d = 16'(fp_m);
            mem_m[fp_m] = w; mem_m[fp_m + 1] = c;
            known_m[fp_m] = 1'b1; known_m[fp_m + 1] = 1'b1;
            fp_m = fp_m + 2;
        end
        dout_m = d; dout_known_m = dk;
    endtask

    // Drive one request and wait (bounded) for data_ready; lat = -1 on timeout.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] w,
                         input logic [15:0] c, output int lat, output logic [15:0] d,
                         output logic e, output logic b);
        @(negedge clk);
        req = 1'b1; op = o; addr_in = a; wdata = w; wdata_cdr = c;
        @(posedge clk); #1;
        req = 1'b0;
        b = busy;
        lat = -1; d = 16'hxxxx; e = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (data_ready) begin
                lat = k; d = data_out; e = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        fp_m = int'(HEAP_BASE); dout_m = LISP_NIL; dout_known_m = 1'b1;
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", data_ready); end
        vectors++; if (data_out !== LISP_NIL) begin miscompares++; $display("FAIL reset_dout: got %h expected %h", data_out, LISP_NIL); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
        vectors++; if (free_ptr !== HEAP_BASE) begin miscompares++; $display("FAIL reset_free_ptr: got %h expected %h", free_ptr, HEAP_BASE); end
    endtask

    task automatic test_cons();
        int lat, mlat; logic [15:0] d, md; logic e, me, b; bit mk;
        model_apply(2'd2, 16'h0000, 16'h1234, LISP_NIL, mlat, md, me, mk);
        issue(2'd2, 16'h0000, 16'h1234, LISP_NIL, lat, d, e, b);
        vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL cons_busy: got %b expected 1", b); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL cons_latency: got %0d expected 2", lat); end
        vectors++; if (d !== 16'h0010) begin miscompares++; $display("FAIL cons_addr: got %h expected 0010", d); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL cons_err: got %b expected 0", e); end
        vectors++; if (free_ptr !== 16'h0012) begin miscompares++; $display("FAIL cons_free_ptr: got %h expected 0012", free_ptr); end
    endtask

    task automatic test_read();
        int lat, mlat; logic [15:0] d, md; logic e, me, b; bit mk;
        model_apply(2'd0, 16'h0010, 16'h0000, 16'h0000, mlat, md, me, mk);
        issue(2'd0, 16'h0010, 16'h0000, 16'h0000, lat, d, e, b);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL read_car_latency: got %0d expected 2", lat); end
        vectors++; if (d !== 16'h1234) begin miscompares++; $display("FAIL read_car: got %h expected 1234", d); end
        model_apply(2'd0, 16'h0011, 16'h0000, 16'h0000, mlat, md, me, mk);
        issue(2'd0, 16'h0011, 16'h0000, 16'h0000, lat, d, e, b);
        vectors++; if (d !== LISP_NIL || lat !== 2) begin miscompares++; $display("FAIL read_cdr: got %h lat %0d expected %h lat 2", d, lat, LISP_NIL); end
    endtask

    task automatic test_write_busy_ignore();
        int lat, mlat, extra; logic [15:0] d, md; logic e, me, b; bit mk;
        model_apply(2'd1, 16'h001C, 16'hBEEF, 16'h0000, mlat, md, me, mk);
        @(negedge clk);
        req = 1'b1; op = 2'd1; addr_in = 16'h001C; wdata = 16'hBEEF;
        @(posedge clk); #1;
        op = 2'd0; addr_in = 16'h0003;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy: got %b expected 1", busy); end
        @(posedge clk); #1;
        vectors++; if (data_ready !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL write_ready: got ready=%b err=%b expected 1/0", data_ready, err); end
        req = 1'b0;
        extra = 0;
        repeat (4) begin @(posedge clk); #1; if (data_ready) extra++; end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL busy_req_ignored: got %0d completions expected 0", extra); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
        model_apply(2'd0, 16'h001C, 16'h0000, 16'h0000, mlat, md, me, mk);
        issue(2'd0, 16'h001C, 16'h0000, 16'h0000, lat, d, e, b);
        vectors++; if (d !== 16'hBEEF) begin miscompares++; $display("FAIL write_readback: got %h expected BEEF", d); end
    endtask

    task automatic test_back_to_back();
        int lat, mlat; logic [15:0] d, md, v; logic e, me, b; bit mk;
        v = 16'($urandom);
        model_apply(2'd1, 16'h001D, v, 16'h0000, mlat, md, me, mk);
        issue(2'd1, 16'h001D, v, 16'h0000, lat, d, e, b);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL write_latency: got %0d expected 1", lat); end
        model_apply(2'd0, 16'h001D, 16'h0000, 16'h0000, mlat, md, me, mk);
        issue(2'd0, 16'h001D, 16'h0000, 16'h0000, lat, d, e, b);
        vectors++; if (d !== md || lat !== 2) begin miscompares++; $display("FAIL raw_read: got %h lat %0d expected %h lat 2", d, lat, md); end
    endtask

    task automatic test_random();
        int lat, mlat, r, sel; logic [15:0] d, md, a, w, c; logic e, me, b; bit mk; logic [1:0] o;
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 99));
            o = (r < 35) ? 2'd0 : (r < 65) ? 2'd1 : (r < 85) ? 2'd2 : 2'd3;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      a = HEAP_BASE + 16'($urandom_range(0, 15));
            else if (sel < 8) a = 16'($urandom_range(0, 15));
            else              a = 16'h0100 + 16'($urandom_range(0, 63));
            w = 16'($urandom); c = 16'($urandom);
            model_apply(o, a, w, c, mlat, md, me, mk);
            issue(o, a, w, c, lat, d, e, b);
            vectors++; if (lat !== mlat) begin miscompares++; $display("FAIL rand_latency[%0d] op %0d addr %h: got %0d expected %0d", i, o, a, lat, mlat); end
            vectors++; if (e !== me) begin miscompares++; $display("FAIL rand_err[%0d] op %0d addr %h: got %b expected %b", i, o, a, e, me); end
            if (mk) begin
                vectors++; if (d !== md) begin miscompares++; $display("FAIL rand_data[%0d] op %0d addr %h: got %h expected %h", i, o, a, d, md); end
            end
            vectors++; if (free_ptr !== 16'(fp_m)) begin miscompares++; $display("FAIL rand_free_ptr[%0d]: got %h expected %h", i, free_ptr, 16'(fp_m)); end
        end
    endtask

    task automatic test_heap_full();
        int lat, mlat; logic [15:0] d, md, w, c; logic e, me, b; bit mk;
        test_reset();
        for (int i = 0; i < 8; i++) begin
            w = 16'($urandom); c = 16'($urandom);
            model_apply(2'd2, 16'h0000, w, c, mlat, md, me, mk);
            issue(2'd2, 16'h0000, w, c, lat, d, e, b);
            vectors++; if (d !== 16'(16 + 2 * i) || lat !== 2 || e !== 1'b0) begin miscompares++; $display("FAIL fill_cons[%0d]: got %h lat %0d err %b expected %h lat 2 err 0", i, d, lat, e, 16'(16 + 2 * i)); end
        end
        model_apply(2'd2, 16'h0000, 16'h5555, 16'hAAAA, mlat, md, me, mk);
        issue(2'd2, 16'h0000, 16'h5555, 16'hAAAA, lat, d, e, b);
        vectors++; if (e !== 1'b1 || lat !== 1) begin miscompares++; $display("FAIL full_err: got err %b lat %0d expected err 1 lat 1", e, lat); end
        vectors++; if (d !== LISP_NIL) begin miscompares++; $display("FAIL full_dout: got %h expected %h", d, LISP_NIL); end
        vectors++; if (free_ptr !== 16'h0020) begin miscompares++; $display("FAIL full_free_ptr: got %h expected 0020", free_ptr); end
        model_apply(2'd3, 16'h0012, 16'h0000, 16'h0000, mlat, md, me, mk);
        issue(2'd3, 16'h0012, 16'h0000, 16'h0000, lat, d, e, b);
        vectors++; if (e !== 1'b1 || lat !== 1 || d !== LISP_NIL) begin miscompares++; $display("FAIL reserved_op: got err %b lat %0d dout %h expected 1 1 %h", e, lat, d, LISP_NIL); end
        model_apply(2'd0, 16'h001F, 16'h0000, 16'h0000, mlat, md, me, mk);
        issue(2'd0, 16'h001F, 16'h0000, 16'h0000, lat, d, e, b);
        vectors++; if (d !== md) begin miscompares++; $display("FAIL last_cdr: got %h expected %h", d, md); end
    endtask

    task automatic test_bounds();
        int lat, mlat; logic [15:0] d, md; logic e, me, b; bit mk;
        model_apply(2'd1, 16'h0000, 16'hA5A5, 16'h0000, mlat, md, me, mk);
        issue(2'd1, 16'h0000, 16'hA5A5, 16'h0000, lat, d, e, b);
        vectors++; if (e !== me || lat !== mlat) begin miscompares++; $display("FAIL image_write: got err %b lat %0d expected err %b lat %0d", e, lat, me, mlat); end
        model_apply(2'd0, 16'h0100, 16'h0000, 16'h0000, mlat, md, me, mk);
        issue(2'd0, 16'h0100, 16'h0000, 16'h0000, lat, d, e, b);
        vectors++; if (e !== me || lat !== mlat) begin miscompares++; $display("FAIL oob_read: got err %b lat %0d expected err %b lat %0d", e, lat, me, mlat); end
        if (mk) begin
            vectors++; if (d !== md) begin miscompares++; $display("FAIL oob_read_data: got %h expected %h", d, md); end
        end
        model_apply(2'd1, 16'h0105, 16'h7E57, 16'h0000, mlat, md, me, mk);
        issue(2'd1, 16'h0105, 16'h7E57, 16'h0000, lat, d, e, b);
        vectors++; if (e !== me || lat !== mlat) begin miscompares++; $display("FAIL oob_write: got err %b lat %0d expected err %b lat %0d", e, lat, me, mlat); end
    endtask

    task automatic test_rst_mid_cons();
        int lat, mlat, extra; logic [15:0] d, md; logic e, me, b; bit mk;
        test_reset();
        @(negedge clk);
        req = 1'b1; op = 2'd2; addr_in = 16'h0000; wdata = 16'hC0DE; wdata_cdr = 16'hD00D;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        mem_m[16] = 16'hC0DE; known_m[16] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fp_m = int'(HEAP_BASE); dout_m = LISP_NIL; dout_known_m = 1'b1;
        vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL rst_abort_ready: got %b expected 0", data_ready); end
        vectors++; if (free_ptr !== 16'h0010) begin miscompares++; $display("FAIL rst_abort_free_ptr: got %h expected 0010", free_ptr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_abort_busy: got %b expected 0", busy); end
        extra = 0;
        repeat (3) begin @(posedge clk); #1; if (data_ready) extra++; end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL rst_abort_late_ready: got %0d expected 0", extra); end
        model_apply(2'd0, 16'h0010, 16'h0000, 16'h0000, mlat, md, me, mk);
        issue(2'd0, 16'h0010, 16'h0000, 16'h0000, lat, d, e, b);
        vectors++; if (d !== 16'hC0DE) begin miscompares++; $display("FAIL orphan_car: got %h expected C0DE", d); end
        model_apply(2'd0, 16'h0011, 16'h0000, 16'h0000, mlat, md, me, mk);
        issue(2'd0, 16'h0011, 16'h0000, 16'h0000, lat, d, e, b);
        vectors++; if (d !== md) begin miscompares++; $display("FAIL aborted_cdr: got %h expected %h", d, md); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            known_m[i] = 1'b0;
            mem_m[i]   = 16'h0000;
        end
        test_reset();
        test_cons();
        test_read();
        test_write_busy_ignore();
        test_back_to_back();
        test_random();
        test_heap_full();
        test_bounds();
        test_rst_mid_cons();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
